// File: rtl/alu_req_arbiter_if.sv
// Request, ALU and response signals shared by the arbiter and its neighbours.
// The slave modport is the arbiter's view; the master modport is the view from requesters, ALU and consumer.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_opcode;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_opcode;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req1_ready,
    output alu_opcode, alu_a, alu_b,
    input  alu_result,
    output resp_valid, resp_id, resp_data,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req1_ready,
    input  alu_opcode, alu_a, alu_b,
    output alu_result,
    input  resp_valid, resp_id, resp_data,
    output resp_ready
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// registered, ID-tagged response channel.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; only state in which reqN_ready can be 1
// EXEC    | operands held on alu_*, exec counter runs down to capture
// RESP    | result held on resp_* until the consumer takes it
module alu_req_arbiter #(
  parameter int DATA_W      = 4,
  parameter int OP_W        = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_req_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] exec_cnt;
  logic             last_grant;
  logic             grant_vld;
  logic             grant_id;

  // ready is gated by rst_n so it reads 0 throughout reset, not just after the first edge
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (rst_n && state == ST_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_vld && !grant_id;
  assign bus.req1_ready = grant_vld && grant_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      exec_cnt       <= '0;
      last_grant     <= 1'b1;
      bus.alu_opcode <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= 1'b0;
      bus.resp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            bus.alu_opcode <= grant_id ? bus.req1_opcode : bus.req0_opcode;
            bus.alu_a      <= grant_id ? bus.req1_a      : bus.req0_a;
            bus.alu_b      <= grant_id ? bus.req1_b      : bus.req0_b;
            bus.resp_id    <= grant_id;
            last_grant     <= grant_id;
            exec_cnt       <= CNT_INIT;
            state          <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_cnt == '0) begin
            bus.resp_data  <= bus.alu_result;
            bus.resp_valid <= 1'b1;
            state          <= ST_RESP;
          end else begin
            exec_cnt <= exec_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          // handshake cycle goes back to IDLE; the next accept is one cycle later
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.alu_opcode <= '0;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
